// File: rtl/bist16_pkg.sv
// Shared encodings and helpers for the 16-bit logic-part self-test engine.
package bist16_pkg;

  localparam logic [1:0]  OP_AND    = 2'd0;
  localparam logic [1:0]  OP_OR     = 2'd1;
  localparam logic [1:0]  OP_XOR    = 2'd2;
  localparam logic [1:0]  OP_NOT    = 2'd3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One step of the right-shifting Galois LFSR; nonzero states never reach 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Reference result of the part under test; NOT ignores b.
  function automatic logic [15:0] golden(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bist16_engine_lfsr16.sv
// 16-bit Galois LFSR operand generator with seed load; a zero seed maps to 1.
module lfsr16
  import bist16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  // Load has priority over step so a restart always begins at the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= 16'h0000;
    else if (load) q <= (seed == 16'h0000) ? 16'h0001 : seed;
    else if (step) q <= lfsr_next(q);
  end

endmodule

// File: rtl/bist16_engine.sv
// Self-test engine: drives LFSR operands into a 16-bit logic part, checks
// its result one cycle later against the golden op, counts and logs failures.
module bist16_engine
  import bist16_pkg::*;
#(
  parameter int          NVEC   = 10000,
  parameter logic [15:0] SEED_A = 16'hACE1,
  parameter logic [15:0] SEED_B = 16'h1D2B,
  parameter logic [1:0]  OP     = OP_OR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] a,
  output logic [15:0] b,
  input  logic [15:0] dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] fail_cnt,
  output logic [15:0] vec_cnt,
  output logic        ff_valid,
  output logic [15:0] ff_a,
  output logic [15:0] ff_b,
  output logic [15:0] ff_out
);

  localparam logic [15:0] LAST_VEC = 16'(NVEC - 1);

  state_t state;
  logic   mismatch, last_vec, run_cmp, launch, adv;

  assign mismatch = (dut_out != golden(OP, a, b));
  assign last_vec = (vec_cnt == LAST_VEC);
  assign run_cmp  = (state == ST_RUN) && !abort;
  assign launch   = (state != ST_RUN) && start && !abort;
  // The final vector stays on the operand bus after the run completes.
  assign adv      = run_cmp && !last_vec;

  lfsr16 u_lfsr_a (.clk(clk), .rst_n(rst_n), .load(launch), .seed(SEED_A), .step(adv), .q(a));
  lfsr16 u_lfsr_b (.clk(clk), .rst_n(rst_n), .load(launch), .seed(SEED_B), .step(adv), .q(b));

  // Run control, comparison counters and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= 16'h0000;
      vec_cnt  <= 16'h0000;
      ff_valid <= 1'b0;
      ff_a     <= 16'h0000;
      ff_b     <= 16'h0000;
      ff_out   <= 16'h0000;
    end else begin
      case (state)
        ST_RUN: begin
          if (abort) begin
            // Counters are left untouched so software can read where it stopped.
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            if (mismatch) begin
              if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
              if (!ff_valid) begin
                ff_valid <= 1'b1;
                ff_a     <= a;
                ff_b     <= b;
                ff_out   <= dut_out;
              end
            end
            vec_cnt <= vec_cnt + 16'd1;
            if (last_vec) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_cnt == 16'h0000) && !mismatch;
            end
          end
        end
        default: begin
          // IDLE and DONE behave alike; abort beats start.
          if (abort) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_cnt <= 16'h0000;
            vec_cnt  <= 16'h0000;
            ff_valid <= 1'b0;
            ff_a     <= 16'h0000;
            ff_b     <= 16'h0000;
            ff_out   <= 16'h0000;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist16_engine.sv
// Directed-plus-random bench for bist16_engine with three configurations.
module tb_bist16_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start0, start1, start2, abort0, abort_x;
  int   fmode;
  logic [15:0] fkey, fmask;

  logic [15:0] a0, b0, d0, fc0, vc0, ffa0, ffb0, ffo0;
  logic        bsy0, dn0, ps0, ffv0;
  logic [15:0] a1, b1, d1, fc1, vc1, ffa1, ffb1, ffo1;
  logic        bsy1, dn1, ps1, ffv1;
  logic [15:0] a2, b2, d2, fc2, vc2, ffa2, ffb2, ffo2;
  logic        bsy2, dn2, ps2, ffv2;

  int checks = 0;
  int errors = 0;

  // Model of the part on dut0's bus: correct OR, stuck-low bit 0, or a
  // keyed random corruption of selected vectors.
  function automatic logic [15:0] dut_fn(input logic [15:0] a, input logic [15:0] b,
                                         input int mode, input logic [15:0] key,
                                         input logic [15:0] mask);
    logic [15:0] r;
    r = a | b;
    if (mode == 1) r = r & 16'hFFFE;
    else if (mode == 2 && ((a ^ key) % 16'd5) == 16'd0) r = r ^ mask;
    return r;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] q);
    logic [15:0] s;
    s = q / 16'd2;
    if (q % 16'd2 == 16'd1) s = s ^ 16'hB400;
    return s;
  endfunction

  assign d0 = dut_fn(a0, b0, fmode, fkey, fmask);
  assign d1 = a1 | b1;
  assign d2 = ~a2;

  bist16_engine #(.NVEC(100), .OP(2'd1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .a(a0), .b(b0),
    .dut_out(d0), .busy(bsy0), .done(dn0), .pass(ps0), .fail_cnt(fc0), .vec_cnt(vc0),
    .ff_valid(ffv0), .ff_a(ffa0), .ff_b(ffb0), .ff_out(ffo0));

  bist16_engine #(.NVEC(4), .SEED_A(16'h0000), .OP(2'd1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort_x), .a(a1), .b(b1),
    .dut_out(d1), .busy(bsy1), .done(dn1), .pass(ps1), .fail_cnt(fc1), .vec_cnt(vc1),
    .ff_valid(ffv1), .ff_a(ffa1), .ff_b(ffb1), .ff_out(ffo1));

  bist16_engine #(.NVEC(8), .OP(2'd3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort_x), .a(a2), .b(b2),
    .dut_out(d2), .busy(bsy2), .done(dn2), .pass(ps2), .fail_cnt(fc2), .vec_cnt(vc2),
    .ff_valid(ffv2), .ff_a(ffa2), .ff_b(ffb2), .ff_out(ffo2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk the vector list an OR-checking engine would apply to dut0's part.
  task automatic model_run(input int n, input int mode, input logic [15:0] key,
                           input logic [15:0] mask, output int fails,
                           output logic [15:0] fa, output logic [15:0] fb,
                           output logic [15:0] fo, output logic [15:0] last_a);
    logic [15:0] va, vb, o;
    bit found;
    va = 16'hACE1; vb = 16'h1D2B; fails = 0; found = 0;
    fa = 0; fb = 0; fo = 0;
    for (int i = 0; i < n; i++) begin
      o = dut_fn(va, vb, mode, key, mask);
      if (o != (va | vb)) begin
        if (fails < 65535) fails++;
        if (!found) begin found = 1; fa = va; fb = vb; fo = o; end
      end
      if (i < n - 1) begin va = lstep(va); vb = lstep(vb); end
    end
    last_a = va;
  endtask

  task automatic run0(output int edges);
    start0 = 1'b1; tick(); start0 = 1'b0; edges = 1;
    while (!dn0 && edges < 300) begin tick(); edges++; end
  endtask

  initial begin
    int edges, k, mf;
    logic [15:0] ma, mb, mo, ml, va, vb;
    rst_n = 1'b0; start0 = 0; start1 = 0; start2 = 0; abort0 = 0; abort_x = 0;
    fmode = 0; fkey = 0; fmask = 0;
    #12;
    chk("rst_a", a0, 0); chk("rst_b", b0, 0); chk("rst_busy", bsy0, 0);
    chk("rst_done", dn0, 0); chk("rst_pass", ps0, 0); chk("rst_vec", vc0, 0);
    chk("rst_fail", fc0, 0); chk("rst_ffv", ffv0, 0);
    rst_n = 1'b1; tick();

    // Clean run with first-vector checks and latency.
    model_run(100, 0, 0, 0, mf, ma, mb, mo, ml);
    start0 = 1'b1; tick(); start0 = 1'b0; edges = 1;
    chk("first_a", a0, 16'hACE1); chk("first_b", b0, 16'h1D2B); chk("first_busy", bsy0, 1);
    tick(); edges++;
    chk("step_a", a0, lstep(16'hACE1)); chk("step_b", b0, lstep(16'h1D2B)); chk("step_vec", vc0, 1);
    while (!dn0 && edges < 300) begin tick(); edges++; end
    chk("good_edges", edges, 101); chk("good_pass", ps0, 1); chk("good_fail", fc0, 0);
    chk("good_vec", vc0, 100); chk("good_hold_a", a0, ml); chk("good_ffv", ffv0, 0);

    // Stuck-low bit 0 fault.
    fmode = 1;
    model_run(100, 1, 0, 0, mf, ma, mb, mo, ml);
    run0(edges);
    chk("b0_done", dn0, 1); chk("b0_fail", fc0, mf); chk("b0_ffa", ffa0, 16'hACE1);
    chk("b0_ffb", ffb0, mb); chk("b0_ffo", ffo0, mo); chk("b0_ffv", ffv0, 1); chk("b0_pass", ps0, 0);

    // Randomly keyed corruption patterns.
    fmode = 2;
    for (int r = 0; r < 3; r++) begin
      fkey = 16'($urandom); fmask = 16'($urandom_range(1, 65535));
      model_run(100, 2, fkey, fmask, mf, ma, mb, mo, ml);
      run0(edges);
      chk("rnd_edges", edges, 101); chk("rnd_fail", fc0, mf); chk("rnd_pass", ps0, mf == 0);
      chk("rnd_ffv", ffv0, mf != 0); chk("rnd_ffa", ffa0, ma); chk("rnd_ffo", ffo0, mo);
    end

    // Abort beats start while in DONE.
    abort0 = 1; start0 = 1; tick(); abort0 = 0; start0 = 0;
    chk("ab_done_done", dn0, 0); chk("ab_done_busy", bsy0, 0); chk("ab_done_pass", ps0, 0);

    // Abort mid-run keeps the vector count.
    fmode = 0;
    k = $urandom_range(5, 90);
    start0 = 1; tick(); start0 = 0; edges = 1;
    while (vc0 != 16'(k) && edges < 300) begin tick(); edges++; end
    abort0 = 1; tick(); abort0 = 0;
    chk("ab_busy", bsy0, 0); chk("ab_done", dn0, 0); chk("ab_vec", vc0, k);
    tick(); tick();
    chk("ab_vec_hold", vc0, k); chk("ab_idle_busy", bsy0, 0);

    // NOT engine: start during RUN must be ignored.
    start2 = 1; tick(); start2 = 0; edges = 1;
    while (!dn2 && edges < 300) begin tick(); edges++; start2 = (vc2 == 16'd2); end
    start2 = 0;
    va = 16'hACE1; for (int i = 0; i < 7; i++) va = lstep(va);
    chk("not_edges", edges, 9); chk("not_vec", vc2, 8); chk("not_pass", ps2, 1);
    chk("not_fail", fc2, 0); chk("not_hold_a", a2, va);
    tick(); tick();
    chk("not_done_hold", dn2, 1); chk("not_vec_hold", vc2, 8);

    // Short run from a zero seed.
    start1 = 1; tick(); start1 = 0; edges = 1;
    chk("z_a", a1, 16'h0001); chk("z_b", b1, 16'h1D2B);
    while (!dn1 && edges < 300) begin tick(); edges++; end
    chk("z_edges", edges, 5); chk("z_pass", ps1, 1); chk("z_vec", vc1, 4); chk("z_fail", fc1, 0);

    // Asynchronous reset mid-run, then an identical replay.
    fmode = 1;
    start0 = 1; tick(); start0 = 0; edges = 1;
    while (vc0 != 16'd50 && edges < 300) begin tick(); edges++; end
    rst_n = 0; #1;
    chk("mr_a", a0, 0); chk("mr_b", b0, 0); chk("mr_busy", bsy0, 0); chk("mr_done", dn0, 0);
    chk("mr_vec", vc0, 0); chk("mr_fail", fc0, 0); chk("mr_ffv", ffv0, 0); chk("mr_ffa", ffa0, 0);
    #1 rst_n = 1; tick();
    chk("mr_idle", bsy0, 0);
    start0 = 1; tick(); start0 = 0;
    va = 16'hACE1; vb = 16'h1D2B;
    for (int i = 0; i < 6; i++) begin
      chk("rp_a", a0, va); chk("rp_b", b0, vb);
      va = lstep(va); vb = lstep(vb); tick();
    end
    model_run(100, 1, 0, 0, mf, ma, mb, mo, ml);
    edges = 0;
    while (!dn0 && edges < 300) begin tick(); edges++; end
    chk("rp_done", dn0, 1); chk("rp_fail", fc0, mf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
